// File: rtl/lfa_share_pkg.sv
// Shared types, widths and the round-robin pick helper for the LFA share arbiter.
package lfa_share_pkg;

    localparam int OPW  = 16;
    localparam int SUMW = 17;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} stateT;

    // Scans valid from ptr upward, modulo 8. Callers zero-pad unused requester
    // slots, which gives the same winner as a scan modulo the real count.
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr);
        logic [7:0] grant;
        logic [2:0] idx;
        logic       found;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/LFA_15_0.sv
// Exact 16-bit Ladner-Fischer (minimum-depth) prefix adder; s[16] is carry-out.
module LFA_15_0
    import lfa_share_pkg::*;
(
    output logic [SUMW-1:0] s,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b
);

    logic [OPW-1:0] gL [5];
    logic [OPW-1:0] pL [5];

    always_comb begin
        int unsigned j;
        j = 0;
        gL[0] = a & b;
        pL[0] = a ^ b;
        for (int unsigned l = 0; l < 4; l++) begin
            for (int unsigned i = 0; i < OPW; i++) begin
                // Upper half of each 2^(l+1) block merges with the top of its lower half.
                if (((i >> l) & 1) == 1) begin
                    j = ((i >> l) << l) - 1;
                    gL[l+1][i] = gL[l][i] | (pL[l][i] & gL[l][j]);
                    pL[l+1][i] = pL[l][i] & pL[l][j];
                end else begin
                    gL[l+1][i] = gL[l][i];
                    pL[l+1][i] = pL[l][i];
                end
            end
        end
        s[0] = pL[0][0];
        for (int unsigned i = 1; i < OPW; i++) begin
            s[i] = pL[0][i] ^ gL[4][i-1];
        end
        s[SUMW-1] = gL[4][OPW-1];
    end

endmodule

// File: rtl/lfa_share_arbiter.sv
// Round-robin share of one LFA_15_0 core among N_REQ requesters; operands are
// held for SETTLE_CYCLES before the sum is registered onto the response channel.
module lfa_share_arbiter
    import lfa_share_pkg::*;
#(
    parameter  int N_REQ         = 2,
    parameter  int SETTLE_CYCLES = 2,
    parameter  int CNT_W         = 32,
    localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [OPW*N_REQ-1:0] req_a,
    input  logic [OPW*N_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SUMW-1:0]      rsp_sum,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    stateT           state;
    logic [2:0]      rrPtr;
    logic [3:0]      cnt;
    logic [OPW-1:0]  opA;
    logic [OPW-1:0]  opB;
    logic [ID_W-1:0] opId;

    logic [7:0]      validPad;
    logic [7:0]      grantAll;
    logic            accept;
    logic [OPW-1:0]  selA;
    logic [OPW-1:0]  selB;
    logic [ID_W-1:0] selId;
    logic [2:0]      nextPtr;
    logic [SUMW-1:0] adderSum;

    always_comb begin
        validPad              = '0;
        validPad[N_REQ-1:0]   = req_valid;
        grantAll              = rr_pick(validPad, rrPtr);
        accept                = (state == IDLE) && (|grantAll);
        req_ready             = '0;
        if (state == IDLE) begin
            req_ready = grantAll[N_REQ-1:0];
        end
        selA    = '0;
        selB    = '0;
        selId   = '0;
        nextPtr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grantAll[i]) begin
                selA    = req_a[OPW*i +: OPW];
                selB    = req_b[OPW*i +: OPW];
                selId   = ID_W'(i);
                nextPtr = (i + 1 < N_REQ) ? 3'(i + 1) : 3'd0;
            end
        end
    end

    // The core only ever sees the latched operands, never the live request bus.
    LFA_15_0 adder (
        .s (adderSum),
        .a (opA),
        .b (opB)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rrPtr     <= '0;
            cnt       <= '0;
            opA       <= '0;
            opB       <= '0;
            opId      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opA   <= selA;
                        opB   <= selB;
                        opId  <= selId;
                        rrPtr <= nextPtr;
                        cnt   <= 4'(SETTLE_CYCLES - 1);
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_sum   <= adderSum;
                        rsp_id    <= opId;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
